// File: rtl/axi4_xbar_pkg.sv
// Shared types and widths for the AXI4 crossbar read/write muxes.
//   ar_payload_t : slave-side AR channel payload (ID already extended)
//   r_payload_t  : master-side R beat (ID with the routing bits stripped)
package axi4_xbar_pkg;
  localparam int EXTRA_ID_LEN        = 2;
  localparam int R_ID_LEN            = 4;
  localparam int ADDR_WIDTH          = 32;
  localparam int DATA_WIDTH          = 32;
  localparam int STRB_WIDTH          = DATA_WIDTH / 8;
  localparam int S_ID_LEN            = EXTRA_ID_LEN + R_ID_LEN;
  localparam int MAX_OUTSTANDING_DEF = 8;

  // Counter must hold 0..max inclusive.
  function automatic int outst_w(input int max_o);
    return $clog2(max_o + 1);
  endfunction

  localparam int OUTST_W = outst_w(MAX_OUTSTANDING_DEF);

  typedef struct packed {
    logic [S_ID_LEN-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [1:0]            lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } ar_payload_t;

  typedef struct packed {
    logic [R_ID_LEN-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
  } r_payload_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Search starts at the internal pointer and wraps; the
// pointer moves to just past the winner whenever advance_i is high.
//   req_i       : request vector
//   advance_i   : grant consumed this cycle
//   grant_o     : one-hot grant, grant_idx_o its index, grant_vld_o any request
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_vld_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] hi_idx, lo_idx;
  logic          hi_found, lo_found;

  // Two passes: lowest request at/above the pointer, else lowest overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx   = IW'(i);
        lo_found = 1'b1;
        if (IW'(i) >= ptr_q) begin
          hi_idx   = IW'(i);
          hi_found = 1'b1;
        end
      end
    end
    grant_idx_o = hi_found ? hi_idx : lo_idx;
    grant_vld_o = lo_found;
    grant_o     = '0;
    grant_o[grant_idx_o] = lo_found;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && grant_vld_o)
      ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : IW'(grant_idx_o + 1'b1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/axi4_read_mux.sv
// N-master to 1-slave AXI4 read mux (AR + R).
//   m_AR*_i / m_ARREADY_o : master AR ports, round-robin into one AR slot
//   s_AR*_o / s_ARREADY_i : registered slave AR; ID = {master index, master ID}
//   s_R*_i  / s_RREADY_o  : slave R, routed combinationally by upper ID bits
//   m_R*_o  / m_RREADY_i  : per-master R
//   decerr_o              : one-cycle pulse after an R beat to a nonexistent master
module axi4_read_mux
  import axi4_xbar_pkg::*;
#(
  parameter int MASTER_NUM      = 4,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                                  ACLK,
  input  logic                                  ARESETn,
  input  logic [MASTER_NUM-1:0][R_ID_LEN-1:0]   m_ARID_i,
  input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_ARADDR_i,
  input  logic [MASTER_NUM-1:0][7:0]            m_ARLEN_i,
  input  logic [MASTER_NUM-1:0][2:0]            m_ARSIZE_i,
  input  logic [MASTER_NUM-1:0][1:0]            m_ARBURST_i,
  input  logic [MASTER_NUM-1:0][1:0]            m_ARLOCK_i,
  input  logic [MASTER_NUM-1:0][3:0]            m_ARCACHE_i,
  input  logic [MASTER_NUM-1:0][2:0]            m_ARPROT_i,
  input  logic [MASTER_NUM-1:0]                 m_ARVALID_i,
  output logic [MASTER_NUM-1:0]                 m_ARREADY_o,
  output logic [MASTER_NUM-1:0][R_ID_LEN-1:0]   m_RID_o,
  output logic [MASTER_NUM-1:0][DATA_WIDTH-1:0] m_RDATA_o,
  output logic [MASTER_NUM-1:0][STRB_WIDTH-1:0] m_RSTRB_o,
  output logic [MASTER_NUM-1:0]                 m_RLAST_o,
  output logic [MASTER_NUM-1:0]                 m_RVALID_o,
  input  logic [MASTER_NUM-1:0]                 m_RREADY_i,
  output logic [S_ID_LEN-1:0]                   s_ARID_o,
  output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
  output logic [7:0]                            s_ARLEN_o,
  output logic [2:0]                            s_ARSIZE_o,
  output logic [1:0]                            s_ARBURST_o,
  output logic [1:0]                            s_ARLOCK_o,
  output logic [3:0]                            s_ARCACHE_o,
  output logic [2:0]                            s_ARPROT_o,
  output logic                                  s_ARVALID_o,
  input  logic                                  s_ARREADY_i,
  input  logic [S_ID_LEN-1:0]                   s_RID_i,
  input  logic [DATA_WIDTH-1:0]                 s_RDATA_i,
  input  logic [STRB_WIDTH-1:0]                 s_RSTRB_i,
  input  logic                                  s_RLAST_i,
  input  logic                                  s_RVALID_i,
  output logic                                  s_RREADY_o,
  output logic                                  decerr_o
);
  localparam int CW = outst_w(MAX_OUTSTANDING);
  localparam int IW = $clog2(MASTER_NUM);

  ar_payload_t                   ar_q, ar_d;
  logic                          s_arvalid_q, s_arvalid_d;
  logic                          decerr_q, decerr_d;
  logic [MASTER_NUM-1:0][CW-1:0] outst_q, outst_d;

  logic [MASTER_NUM-1:0] elig, gnt, hit, rlast_hs;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_vld, slot_free, adv, idx_ok;
  logic [EXTRA_ID_LEN-1:0] r_idx;
  r_payload_t            r_beat;

  // ---------------- AR path ----------------
  assign slot_free = !s_arvalid_q || s_ARREADY_i;

  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++)
      elig[i] = m_ARVALID_i[i] && (outst_q[i] < CW'(MAX_OUTSTANDING));
  end

  rr_arbiter #(.N(MASTER_NUM)) u_arb (
    .clk_i      (ACLK),
    .rst_ni     (ARESETn),
    .req_i      (elig),
    .advance_i  (adv),
    .grant_o    (gnt),
    .grant_idx_o(gnt_idx),
    .grant_vld_o(gnt_vld)
  );

  // Gated by reset so no master sees a handshake while the mux is held in reset.
  assign adv         = ARESETn && slot_free && gnt_vld;
  assign m_ARREADY_o = adv ? gnt : '0;

  always_comb begin
    ar_d        = ar_q;
    s_arvalid_d = s_arvalid_q;
    if (slot_free) begin
      s_arvalid_d = gnt_vld;
      if (gnt_vld) begin
        ar_d.id    = {EXTRA_ID_LEN'(gnt_idx), m_ARID_i[gnt_idx]};
        ar_d.addr  = m_ARADDR_i[gnt_idx];
        ar_d.len   = m_ARLEN_i[gnt_idx];
        ar_d.size  = m_ARSIZE_i[gnt_idx];
        ar_d.burst = m_ARBURST_i[gnt_idx];
        ar_d.lock  = m_ARLOCK_i[gnt_idx];
        ar_d.cache = m_ARCACHE_i[gnt_idx];
        ar_d.prot  = m_ARPROT_i[gnt_idx];
      end
    end
  end

  assign s_ARID_o    = ar_q.id;
  assign s_ARADDR_o  = ar_q.addr;
  assign s_ARLEN_o   = ar_q.len;
  assign s_ARSIZE_o  = ar_q.size;
  assign s_ARBURST_o = ar_q.burst;
  assign s_ARLOCK_o  = ar_q.lock;
  assign s_ARCACHE_o = ar_q.cache;
  assign s_ARPROT_o  = ar_q.prot;
  assign s_ARVALID_o = s_arvalid_q;

  // ---------------- R path (stateless) ----------------
  assign r_idx  = s_RID_i[S_ID_LEN-1:R_ID_LEN];
  assign r_beat = '{id: s_RID_i[R_ID_LEN-1:0], data: s_RDATA_i, strb: s_RSTRB_i, last: s_RLAST_i};

  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++)
      hit[i] = (r_idx == EXTRA_ID_LEN'(i));
  end

  assign idx_ok     = |hit;
  assign m_RVALID_o = s_RVALID_i ? hit : '0;
  // Beats addressed to no master are sunk so the slave never stalls on them.
  assign s_RREADY_o = idx_ok ? |(hit & m_RREADY_i) : 1'b1;
  assign decerr_d   = s_RVALID_i && !idx_ok;
  assign decerr_o   = decerr_q;

  for (genvar g = 0; g < MASTER_NUM; g++) begin : g_r
    assign m_RID_o[g]   = r_beat.id;
    assign m_RDATA_o[g] = r_beat.data;
    assign m_RSTRB_o[g] = r_beat.strb;
    assign m_RLAST_o[g] = r_beat.last;
  end

  // ---------------- outstanding counters ----------------
  assign rlast_hs = (s_RVALID_i && s_RREADY_o && s_RLAST_i) ? hit : '0;

  always_comb begin
    outst_d = outst_q;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (m_ARREADY_o[i] && !rlast_hs[i])
        outst_d[i] = outst_q[i] + 1'b1;
      else if (rlast_hs[i] && !m_ARREADY_o[i] && outst_q[i] != '0)
        outst_d[i] = outst_q[i] - 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      s_arvalid_q <= 1'b0;
      ar_q        <= '0;
      outst_q     <= '0;
      decerr_q    <= 1'b0;
    end else begin
      s_arvalid_q <= s_arvalid_d;
      ar_q        <= ar_d;
      outst_q     <= outst_d;
      decerr_q    <= decerr_d;
    end
  end
endmodule

// File: tb/tb_axi4_read_mux.sv
module tb_axi4_read_mux;
  import axi4_xbar_pkg::*;

  localparam int NM = 3;
  localparam int MO = 2;
  localparam int NCYC = 1500;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [NM-1:0][R_ID_LEN-1:0]   m_ARID;
  logic [NM-1:0][ADDR_WIDTH-1:0] m_ARADDR;
  logic [NM-1:0][7:0]            m_ARLEN;
  logic [NM-1:0][2:0]            m_ARSIZE;
  logic [NM-1:0][1:0]            m_ARBURST;
  logic [NM-1:0][1:0]            m_ARLOCK;
  logic [NM-1:0][3:0]            m_ARCACHE;
  logic [NM-1:0][2:0]            m_ARPROT;
  logic [NM-1:0]                 m_ARVALID, m_ARREADY;
  logic [NM-1:0][R_ID_LEN-1:0]   m_RID;
  logic [NM-1:0][DATA_WIDTH-1:0] m_RDATA;
  logic [NM-1:0][STRB_WIDTH-1:0] m_RSTRB;
  logic [NM-1:0]                 m_RLAST, m_RVALID, m_RREADY;
  logic [S_ID_LEN-1:0]           s_ARID;
  logic [ADDR_WIDTH-1:0]         s_ARADDR;
  logic [7:0]                    s_ARLEN;
  logic [2:0]                    s_ARSIZE;
  logic [1:0]                    s_ARBURST, s_ARLOCK;
  logic [3:0]                    s_ARCACHE;
  logic [2:0]                    s_ARPROT;
  logic                          s_ARVALID, s_ARREADY;
  logic [S_ID_LEN-1:0]           s_RID;
  logic [DATA_WIDTH-1:0]         s_RDATA;
  logic [STRB_WIDTH-1:0]         s_RSTRB;
  logic                          s_RLAST, s_RVALID, s_RREADY, decerr;

  axi4_read_mux #(.MASTER_NUM(NM), .MAX_OUTSTANDING(MO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_ARID_i(m_ARID), .m_ARADDR_i(m_ARADDR), .m_ARLEN_i(m_ARLEN), .m_ARSIZE_i(m_ARSIZE),
    .m_ARBURST_i(m_ARBURST), .m_ARLOCK_i(m_ARLOCK), .m_ARCACHE_i(m_ARCACHE), .m_ARPROT_i(m_ARPROT),
    .m_ARVALID_i(m_ARVALID), .m_ARREADY_o(m_ARREADY),
    .m_RID_o(m_RID), .m_RDATA_o(m_RDATA), .m_RSTRB_o(m_RSTRB), .m_RLAST_o(m_RLAST),
    .m_RVALID_o(m_RVALID), .m_RREADY_i(m_RREADY),
    .s_ARID_o(s_ARID), .s_ARADDR_o(s_ARADDR), .s_ARLEN_o(s_ARLEN), .s_ARSIZE_o(s_ARSIZE),
    .s_ARBURST_o(s_ARBURST), .s_ARLOCK_o(s_ARLOCK), .s_ARCACHE_o(s_ARCACHE), .s_ARPROT_o(s_ARPROT),
    .s_ARVALID_o(s_ARVALID), .s_ARREADY_i(s_ARREADY),
    .s_RID_i(s_RID), .s_RDATA_i(s_RDATA), .s_RSTRB_i(s_RSTRB), .s_RLAST_i(s_RLAST),
    .s_RVALID_i(s_RVALID), .s_RREADY_o(s_RREADY), .decerr_o(decerr)
  );

  typedef struct {
    int                    m;
    logic [R_ID_LEN-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
  } rexp_t;

  ar_payload_t arq[$];
  rexp_t       rq[$];

  int errs = 0, checks = 0;

  // Reference state: what the mux should be holding right now.
  int m_ptr = 0;
  int m_cnt[NM];
  bit m_sv = 0;
  bit m_dec = 0;
  bit hs[NM];
  bit r_hs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errs++;
    $display("FAIL %s actual=unexpected-transfer expected=none at %0t", nm, $time);
  endtask

  task automatic new_req(input int i);
    m_ARVALID[i] = ($urandom_range(0, 3) != 0);
    m_ARID[i]    = R_ID_LEN'($urandom);
    m_ARADDR[i]  = $urandom;
    m_ARLEN[i]   = 8'($urandom);
    m_ARSIZE[i]  = 3'($urandom);
    m_ARBURST[i] = 2'($urandom);
    m_ARLOCK[i]  = 2'($urandom);
    m_ARCACHE[i] = 4'($urandom);
    m_ARPROT[i]  = 3'($urandom);
  endtask

  task automatic drive();
    int idx;
    for (int i = 0; i < NM; i++)
      if (hs[i] || !m_ARVALID[i]) new_req(i);
    s_ARREADY = ($urandom_range(0, 9) < 6);
    if (!s_RVALID || r_hs) begin
      s_RVALID = ($urandom_range(0, 2) != 0);
      idx      = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, NM - 1);
      s_RID    = {EXTRA_ID_LEN'(idx), R_ID_LEN'($urandom)};
      s_RDATA  = $urandom;
      s_RSTRB  = STRB_WIDTH'($urandom);
      s_RLAST  = $urandom_range(0, 1) != 0;
    end
    m_RREADY = NM'($urandom);
  endtask

  // Reference model for one cycle: compare outputs, then advance to next state.
  task automatic model_step();
    bit          free, dec;
    int          w, c, idx;
    logic [NM-1:0] exp_rdy, exp_rv;
    logic        exp_srr;
    ar_payload_t p;
    rexp_t       r;

    chk("s_ARVALID", 64'(s_ARVALID), 64'(m_sv));
    free = !m_sv || s_ARREADY;
    w = -1;
    for (int off = 0; off < NM; off++) begin
      c = (m_ptr + off) % NM;
      if (w < 0 && m_ARVALID[c] && m_cnt[c] < MO) w = c;
    end
    exp_rdy = '0;
    if (ARESETn && free && w >= 0) exp_rdy[w] = 1'b1;
    chk("m_ARREADY", 64'(m_ARREADY), 64'(exp_rdy));

    idx = int'(s_RID[S_ID_LEN-1:R_ID_LEN]);
    exp_rv  = '0;
    exp_srr = 1'b1;
    if (idx < NM) begin
      exp_rv[idx] = s_RVALID;
      exp_srr     = m_RREADY[idx];
    end
    chk("m_RVALID", 64'(m_RVALID), 64'(exp_rv));
    chk("s_RREADY", 64'(s_RREADY), 64'(exp_srr));
    chk("decerr", 64'(decerr), 64'(m_dec));

    r_hs = s_RVALID && exp_srr;
    if (r_hs && idx < NM) begin
      r.m = idx; r.id = s_RID[R_ID_LEN-1:0]; r.data = s_RDATA; r.strb = s_RSTRB; r.last = s_RLAST;
      rq.push_back(r);
    end

    m_dec = ARESETn && s_RVALID && idx >= NM;
    for (int i = 0; i < NM; i++) hs[i] = exp_rdy[i];

    if (!ARESETn) begin
      m_sv = 0; m_ptr = 0;
      for (int i = 0; i < NM; i++) m_cnt[i] = 0;
      arq.delete();
    end else begin
      if (free) begin
        if (w >= 0) begin
          p.id    = {EXTRA_ID_LEN'(w), m_ARID[w]};
          p.addr  = m_ARADDR[w];  p.len   = m_ARLEN[w];   p.size = m_ARSIZE[w];
          p.burst = m_ARBURST[w]; p.lock  = m_ARLOCK[w];  p.cache = m_ARCACHE[w];
          p.prot  = m_ARPROT[w];
          arq.push_back(p);
          m_sv  = 1;
          m_ptr = (w + 1) % NM;
        end else m_sv = 0;
      end
      for (int i = 0; i < NM; i++) begin
        dec = r_hs && s_RLAST && idx == i;
        if (exp_rdy[i] && !dec) m_cnt[i]++;
        else if (dec && !exp_rdy[i] && m_cnt[i] > 0) m_cnt[i]--;
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge ACLK) begin
    ar_payload_t a;
    #1;
    if (ARESETn && s_ARVALID) begin
      if (arq.size() == 0) fail_now("s_AR_unexpected");
      else begin
        a.id = s_ARID; a.addr = s_ARADDR; a.len = s_ARLEN; a.size = s_ARSIZE;
        a.burst = s_ARBURST; a.lock = s_ARLOCK; a.cache = s_ARCACHE; a.prot = s_ARPROT;
        chk("s_AR_payload", 64'(a), 64'(arq[0]));
        if (s_ARREADY) void'(arq.pop_front());
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (m_RVALID[i] && m_RREADY[i]) begin
        if (rq.size() == 0) fail_now("m_R_unexpected");
        else begin
          chk("m_R_master", 64'(i), 64'(rq[0].m));
          chk("m_R_beat", {m_RID[i], m_RSTRB[i], m_RLAST[i], m_RDATA[i]},
              {rq[0].id, rq[0].strb, rq[0].last, rq[0].data});
          void'(rq.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NM; i++) begin
      new_req(i);
      m_ARVALID[i] = 1'b1;
      m_cnt[i] = 0;
      hs[i] = 0;
    end
    s_ARREADY = 1'b0;
    s_RVALID = 1'b0; s_RID = '0; s_RDATA = '0; s_RSTRB = '0; s_RLAST = 1'b0;
    m_RREADY = '0;
    @(posedge ACLK); #1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      ARESETn = !(cyc < 2 || cyc == 600 || cyc == 601);
      if (cyc >= 2) drive();
      @(negedge ACLK);
      model_step();
      @(posedge ACLK); #1;
    end
    chk("ar_queue_depth", 64'(arq.size()), 64'(m_sv));
    chk("r_queue_depth", 64'(rq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/axi4_read_mux.md
Name: axi4_read_mux

Overview:
- N-master to 1-slave AXI4 read-path multiplexer (AR + R channels), the first active building block of the crossbar read side.
- Round-robin arbitrates master AR requests into a registered slave-side AR slot.
- Prepends the master index as extra ID bits and routes R beats back by those bits.
- Tracks per-master outstanding bursts and throttles a master at its limit.

Parameters:
- MASTER_NUM, `MASTER_NUM: number of master ports, >=2.
- EXTRA_ID_LEN, `EXTRA_ID_LEN: slave-side extra ID bits; must satisfy 2**EXTRA_ID_LEN >= MASTER_NUM.
- R_ID_LEN, `R_ID_LEN: master-side ID width.
- ADDR_WIDTH, `ADDR_WIDTH: address width.
- DATA_WIDTH, `DATA_WIDTH: data width.
- MAX_OUTSTANDING, 8: max in-flight read bursts per master, >=1.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  synchronous active-low reset.
- m_AR{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,VALID}  in  [MASTER_NUM] x (R_ID_LEN, ADDR_WIDTH, 8, 3, 2, 2, 4, 3, 1)  master AR requests.
- m_ARREADY  out  [MASTER_NUM] x 1  AR accept.
- m_R{ID,DATA,STRB,LAST,VALID}  out  [MASTER_NUM] x (R_ID_LEN, DATA_WIDTH, DATA_WIDTH/8, 1, 1)  returned read data.
- m_RREADY  in  [MASTER_NUM] x 1  master R accept.
- s_AR{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,VALID}  out  EXTRA_ID_LEN+R_ID_LEN, ADDR_WIDTH, 8, 3, 2, 2, 4, 3, 1  slave AR.
- s_ARREADY  in  1  slave AR accept.
- s_R{ID,DATA,STRB,LAST,VALID}  in  EXTRA_ID_LEN+R_ID_LEN, DATA_WIDTH, DATA_WIDTH/8, 1, 1  slave R.
- s_RREADY  out  1  R accept to slave.
- decerr  out  1  one-cycle pulse on a consumed R beat whose extra ID bits address no master.

Behaviour:
- Reset (ARESETn=0 at ACLK edge): s_ARVALID=0, all AR payload regs 0, rr_ptr=0, all outstanding counters 0, decerr=0. Combinational outputs take the value implied by this state: all m_ARREADY=0.
- AR slot: single register. Slot is "free" when s_ARVALID=0 or s_ARREADY=1 in the same cycle.
- Eligible master i: m_ARVALID[i]=1 and outst[i] < MAX_OUTSTANDING.
- Winner: the first eligible master searching rr_ptr, rr_ptr+1, ... mod MASTER_NUM.
- If the slot is free and a winner exists:
  - m_ARREADY[winner]=1 (combinational); all other m_ARREADY=0.
  - Next edge: slot loads winner payload, s_ARID = {winner[EXTRA_ID_LEN-1:0], m_ARID[winner]}, s_ARVALID=1, rr_ptr = winner+1 (wrap at MASTER_NUM).
- If the slot is free and no winner exists: s_ARVALID goes 0 next edge; rr_ptr is unchanged.
- If the slot is not free: all m_ARREADY=0, and the payload holds stable while s_ARVALID=1 (AXI stability rule).
- AR latency: master handshake to s_ARVALID is 1 cycle. Back-to-back issue at one burst per cycle when s_ARREADY stays high.
- R routing is combinational, 0 latency. idx = s_RID[EXTRA_ID_LEN+R_ID_LEN-1 : R_ID_LEN].
  - If idx < MASTER_NUM: m_RVALID[idx]=s_RVALID; that master gets RID/RDATA/RSTRB/RLAST (low R_ID_LEN bits of RID); s_RREADY = m_RREADY[idx]. All other m_RVALID=0.
  - If idx >= MASTER_NUM: s_RREADY=1 (beat sunk) and decerr is registered high for 1 cycle when s_RVALID=1.
- Outstanding counter per master, width $clog2(MAX_OUTSTANDING+1):
  - +1 on the m_ARVALID&m_ARREADY handshake.
  - -1 on s_RVALID&s_RREADY&s_RLAST with idx==i.
  - Both in the same cycle: unchanged.
  - Decrement at 0 (spurious RLAST): saturate at 0.
  - At MAX_OUTSTANDING the master is ineligible until a decrement. A decrement in cycle t makes the master eligible in cycle t+1.
- Reset mid-burst: slot and counters clear; in-flight R beats arriving after reset still route by ID (stateless path).

Decomposition:
- Package axi4_xbar_pkg holds:
  - the ar_payload_t struct (ID extended, ADDR, LEN, SIZE, BURST, LOCK, CACHE, PROT);
  - r_payload_t;
  - the localparams for the extended-ID width and the counter width.
- Sub-module rr_arbiter (parameter N): req[N], advance, grant onehot + index, internal rr_ptr. It is reused later by the write mux.

Test Plan:
- Reset: ARESETn=0 for 2 cycles with all m_ARVALID=1 -> m_ARREADY all 0, s_ARVALID=0. First grant after release goes to master 0.
- Fairness: MASTER_NUM=4, all masters valid continuously, s_ARREADY=1 -> grants 0,1,2,3,0 on consecutive cycles; s_ARID upper bits 0,1,2,3,0.
- Backpressure: s_ARREADY=0 with slot holding ARADDR=0x1000 for 5 cycles -> payload stable, no m_ARREADY asserted. s_ARREADY=1 -> next winner loaded the same cycle.
- R routing: s_RID={2'd2,4'h5}, RLAST=1, m_RREADY[2]=0 for 3 cycles then 1 -> only m_RVALID[2] high, m_RID[2]=5, s_RREADY follows m_RREADY[2]. outst[2] decrements on the accepting cycle.
- Outstanding limit: MAX_OUTSTANDING=2, master 1 issues 2 ARs with no R -> third request stalls (m_ARREADY[1]=0) while master 3 is still granted. Master 1's RLAST accepted -> master 1 granted next cycle.
- Bad ID: MASTER_NUM=3, s_RID upper bits = 3 with s_RVALID=1 -> s_RREADY=1, decerr pulses 1 cycle, no m_RVALID asserted.
